ifu_itcm_ctrl: RTL and testbench
================================

IFU_ITCM_CTRL -- requirements
Module: ifu_itcm_ctrl

Interface
REQ-001 SHALL have parameter ITCM_AW, default 14; ITCM word-address width (64 KB).
REQ-002 SHALL have parameter ITCM_BASE, default 32'h8000_0000; ITCM byte base address, aligned to 4<<ITCM_AW.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with the following ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
REQ-004 SHALL have the fetch request ports:
- ifu_req_valid  in  1  fetch request valid.
- ifu_req_ready  out  1  request accepted when high.
- ifu_req_pc  in  PC_SIZE  fetch byte address.
REQ-005 SHALL have the fetch response ports:
- ifu_rsp_valid  out  1  response valid.
- ifu_rsp_ready  in  1  consumer accepts the response.
- ifu_rsp_instr  out  INSTR_SIZE  fetched instruction.
- ifu_rsp_err  out  1  access fault.
REQ-006 SHALL have the control and ITCM ports:
- ifu_flush  in  1  discard all outstanding responses.
- itcm_cs  out  1  SRAM read strobe.
- itcm_addr  out  ITCM_AW  SRAM word address.
- itcm_rdata  in  32  SRAM read data, valid one cycle after itcm_cs.

Function
REQ-007 SHALL treat a request handshake (req_hsk) as ifu_req_valid & ifu_req_ready, and a response handshake (rsp_hsk) as ifu_rsp_valid & ifu_rsp_ready.
REQ-008 SHALL keep a credit counter (0..2) equal to buffered responses plus in-flight request; ifu_req_ready = (credit < 2) & ~rst, with no combinational path from ifu_rsp_ready.
REQ-009 SHALL update credit each cycle as credit + req_hsk - rsp_hsk.
REQ-010 SHALL drive itcm_cs = req_hsk & ok and itcm_addr = ifu_req_pc[ITCM_AW+1:2], where ok = in-range & pc[1:0]==0.
REQ-011 SHALL register one in-flight flag plus its err bit per req_hsk; the response appears in the following cycle (latency 1).
REQ-012 SHALL hold responses in a 2-entry FIFO with 1-bit pointers and a count.
REQ-013 SHALL source the response from the in-flight entry (bypass: itcm_rdata, or 0 if err) when the FIFO is empty, and from the FIFO head otherwise.
REQ-014 SHALL push an in-flight entry into the FIFO tail when it is not consumed by bypass in its own cycle.
REQ-015 SHALL deliver responses strictly in request order.
REQ-016 SHALL sustain one request and one response per cycle while ifu_rsp_ready=1.
REQ-017 SHALL, on a faulted request, issue no SRAM access and return ifu_rsp_instr=0 with ifu_rsp_err=1.
REQ-018 SHALL, in a cycle with ifu_flush=1, force ifu_rsp_valid=0, empty the FIFO and drop the in-flight entry.
REQ-019 SHALL, when a req_hsk coincides with ifu_flush, keep that request: next cycle credit=1 and its response is returned; otherwise credit=0.
REQ-020 SHALL hold ifu_rsp_valid, ifu_rsp_instr and ifu_rsp_err stable while ifu_rsp_valid=1 & ifu_rsp_ready=0 (FIFO-sourced).
REQ-021 SHALL accept simultaneous push and pop with the FIFO full minus one without loss; overflow is impossible by construction.

Reset
REQ-022 SHALL, while rst=1, force credit=0, FIFO empty, in-flight=0, ifu_rsp_valid=0, ifu_req_ready=0 and itcm_cs=0.
REQ-023 SHALL discard any in-flight or buffered response when rst is asserted mid-operation; none is delivered after release.
REQ-024 SHALL have ifu_req_ready=1 in the first cycle after reset release.

Configuration
REQ-025 SHALL support the macro IFU_ITCM_RANGE_CHK_EN.
REQ-026 SHALL, with the macro defined, flag a fault when pc is outside [ITCM_BASE, ITCM_BASE + 4<<ITCM_AW) or pc[1:0]!=0.
REQ-027 SHALL, without the macro, treat ok as constant 1: the address is truncated (aliased), ifu_rsp_err is tied to 0, and no range logic is present.

Verification
REQ-028 Back-to-back: pc 0x8000_0000, then 0x8000_0004, ifu_rsp_ready=1 -> itcm_cs in both cycles, itcm_addr 0 then 1; responses in the next two cycles, ifu_req_ready constantly 1.
REQ-029 Backpressure: ifu_rsp_ready=0 while issuing 3 requests -> only 2 accepted, ifu_req_ready=0 afterwards; on release, responses for A and B come out in order with data held stable, and ifu_req_ready returns 1 the cycle after the first pop.
REQ-030 Fault (macro on): pc 0x0000_1000, then 0x8000_0002 -> itcm_cs=0 for both; responses have instr 0 and err=1.
REQ-031 Flush: 2 buffered responses, ifu_flush=1 for one cycle -> ifu_rsp_valid=0 in that cycle and the next, credit=0, ifu_req_ready=1.
REQ-032 Flush plus a new request at 0x8000_0040 in the same cycle -> only that response (word 0x10) is delivered next cycle.
REQ-033 rst pulsed with 1 in-flight and 1 buffered response -> no ifu_rsp_valid after release; the first new request gets a response with latency 1.

Source files
------------

// File: rtl/ifu_itcm_ctrl.sv
// ifu_itcm_ctrl: instruction-fetch front end for a single-cycle ITCM SRAM.
// A credit counter limits outstanding fetches to two. Each accepted request
// becomes a one-cycle in-flight entry whose response either bypasses straight
// to the consumer or parks in a 2-entry FIFO, so responses stay in order.
// Optional macro IFU_ITCM_RANGE_CHK_EN adds the address-window and alignment
// fault check. Without it, every address is accepted and aliased into the ITCM.
module ifu_itcm_ctrl #(
   parameter int          ITCM_AW    = 14,
   parameter logic [31:0] ITCM_BASE  = 32'h8000_0000,
   localparam int         PC_SIZE    = 32,
   localparam int         INSTR_SIZE = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [PC_SIZE-1:0]    ifu_req_pc,
   output logic                  ifu_rsp_valid,
   input  logic                  ifu_rsp_ready,
   output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
   output logic                  ifu_rsp_err,
   input  logic                  ifu_flush,
   output logic                  itcm_cs,
   output logic [ITCM_AW-1:0]    itcm_addr,
   input  logic [31:0]           itcm_rdata
);

   logic [1:0]            credit;
   logic                  req_hsk;
   logic                  rsp_hsk;
   logic                  ok;
   logic                  inflight_vld;
   logic                  inflight_err;
   logic [INSTR_SIZE-1:0] fifo_instr [2];
   logic [1:0]            fifo_err;
   logic                  wptr;
   logic                  rptr;
   logic [1:0]            fifo_cnt;
   logic                  fifo_empty;
   logic                  byp_take;
   logic                  push;
   logic                  pop;
   logic [INSTR_SIZE-1:0] byp_instr;
   logic                  rsp_err;
   logic                  rsp_vld_raw;

`ifdef IFU_ITCM_RANGE_CHK_EN
   // Base is aligned to the ITCM size, so the window test is a compare of the upper bits.
   assign ok          = (ifu_req_pc[PC_SIZE-1:ITCM_AW+2] == ITCM_BASE[PC_SIZE-1:ITCM_AW+2]) &&
                        (ifu_req_pc[1:0] == 2'b00);
   assign ifu_rsp_err = rsp_err;
`else
   logic unused_sig;
   assign ok          = 1'b1;
   assign ifu_rsp_err = 1'b0;
   assign unused_sig  = ^{ifu_req_pc[PC_SIZE-1:ITCM_AW+2], ifu_req_pc[1:0], rsp_err};
`endif

   // Request side: accept while fewer than two responses are owed.
   assign ifu_req_ready = (credit < 2'd2) & ~rst;
   assign req_hsk       = ifu_req_valid & ifu_req_ready;
   assign itcm_cs       = req_hsk & ok;
   assign itcm_addr     = ifu_req_pc[ITCM_AW+1:2];

   // Response side: the FIFO head has priority; an empty FIFO exposes the in-flight entry.
   assign fifo_empty    = (fifo_cnt == 2'd0);
   assign byp_instr     = inflight_err ? '0 : itcm_rdata;
   assign rsp_vld_raw   = fifo_empty ? inflight_vld : 1'b1;
   assign ifu_rsp_valid = rsp_vld_raw & ~ifu_flush & ~rst;
   assign ifu_rsp_instr = fifo_empty ? byp_instr : fifo_instr[rptr];
   assign rsp_err       = fifo_empty ? inflight_err : fifo_err[rptr];
   assign rsp_hsk       = ifu_rsp_valid & ifu_rsp_ready;
   assign byp_take      = fifo_empty & rsp_hsk;
   assign push          = inflight_vld & ~byp_take;
   assign pop           = ~fifo_empty & rsp_hsk;

   // Control state: credit, in-flight flag and FIFO pointers; flush keeps only a same-cycle request.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit       <= 2'd0;
         inflight_vld <= 1'b0;
         wptr         <= 1'b0;
         rptr         <= 1'b0;
         fifo_cnt     <= 2'd0;
      end else if (ifu_flush) begin
         credit       <= {1'b0, req_hsk};
         inflight_vld <= req_hsk;
         wptr         <= 1'b0;
         rptr         <= 1'b0;
         fifo_cnt     <= 2'd0;
      end else begin
         credit       <= credit + {1'b0, req_hsk} - {1'b0, rsp_hsk};
         inflight_vld <= req_hsk;
         if (push) wptr <= ~wptr;
         if (pop)  rptr <= ~rptr;
         fifo_cnt     <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   // Data state: fault bit of the in-flight access and the FIFO payload, qualified by the control above.
   always_ff @(posedge clk) begin
      if (req_hsk) inflight_err <= ~ok;
      if (push) begin
         fifo_instr[wptr] <= byp_instr;
         fifo_err[wptr]   <= inflight_err;
      end
   end

endmodule

// File: tb/tb_ifu_itcm_ctrl.sv
// Scoreboard bench for ifu_itcm_ctrl: an SRAM model answers ITCM reads, the
// monitor keeps a queue of owed responses and checks handshakes, SRAM strobes
// and response data against it every cycle.
module tb_ifu_itcm_ctrl;
   localparam int          AW   = 14;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_req_valid = 1'b0;
   logic        ifu_req_ready;
   logic [31:0] ifu_req_pc = '0;
   logic        ifu_rsp_valid;
   logic        ifu_rsp_ready = 1'b1;
   logic [31:0] ifu_rsp_instr;
   logic        ifu_rsp_err;
   logic        ifu_flush = 1'b0;
   logic        itcm_cs;
   logic [AW-1:0] itcm_addr;
   logic [31:0] itcm_rdata;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [32:0] exp_q [$];   // {err, instr} of each owed response, oldest first

   ifu_itcm_ctrl #(.ITCM_AW(AW), .ITCM_BASE(BASE)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
      .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
      .ifu_flush(ifu_flush), .itcm_cs(itcm_cs), .itcm_addr(itcm_addr), .itcm_rdata(itcm_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [AW-1:0] a);
      return 32'h1357_9BDF ^ (32'(a) * 32'h9E37_79B9);
   endfunction

   function automatic bit pc_ok(input logic [31:0] pc);
`ifdef IFU_ITCM_RANGE_CHK_EN
      longint p, lo, hi;
      p  = longint'(pc);
      lo = longint'(BASE);
      hi = lo + (longint'(4) << AW);
      return (p >= lo) && (p < hi) && (pc % 4 == 0);
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [32:0] expect_rsp(input logic [31:0] pc);
      logic [AW-1:0] wa;
      wa = AW'(pc >> 2);
      if (pc_ok(pc)) return {1'b0, word(wa)};
      return {1'b1, 32'h0};
   endfunction

   // SRAM model: data one cycle after a strobe, garbage when not strobed
   always @(posedge clk) itcm_rdata <= itcm_cs ? word(itcm_addr) : $urandom;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: sample mid-cycle, compare against owed responses, then apply this cycle's events
   always @(negedge clk) begin
      bit req_hsk, rsp_hsk, exp_cs;
      if (rst) begin
         chk("rst_rsp_valid", 64'(ifu_rsp_valid), 64'd0);
         chk("rst_req_ready", 64'(ifu_req_ready), 64'd0);
         chk("rst_itcm_cs",   64'(itcm_cs),       64'd0);
         exp_q.delete();
      end else begin
         chk("rsp_valid", 64'(ifu_rsp_valid), 64'((exp_q.size() > 0) && !ifu_flush));
         chk("req_ready", 64'(ifu_req_ready), 64'(exp_q.size() < 2));
         if (ifu_rsp_valid && exp_q.size() > 0) begin
            chk("rsp_instr", 64'(ifu_rsp_instr), 64'(exp_q[0][31:0]));
            chk("rsp_err",   64'(ifu_rsp_err),   64'(exp_q[0][32]));
         end
         rsp_hsk = ifu_rsp_valid && ifu_rsp_ready;
         if (rsp_hsk && exp_q.size() > 0) void'(exp_q.pop_front());
         if (ifu_flush) exp_q.delete();
         req_hsk = ifu_req_valid && ifu_req_ready;
         exp_cs  = req_hsk && pc_ok(ifu_req_pc);
         chk("itcm_cs", 64'(itcm_cs), 64'(exp_cs));
         if (exp_cs) chk("itcm_addr", 64'(itcm_addr), 64'(ifu_req_pc[AW+1:2]));
         if (req_hsk) exp_q.push_back(expect_rsp(ifu_req_pc));
      end
   end

   task automatic cyc(input bit v, input logic [31:0] pc, input bit rdy, input bit fl, input bit r);
      @(posedge clk);
      #1;
      ifu_req_valid = v;
      ifu_req_pc    = pc;
      ifu_rsp_ready = rdy;
      ifu_flush     = fl;
      rst           = r;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] rand_pc();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7) return BASE + (32'($urandom_range(0, (1 << AW) - 1)) << 2);
      if (sel < 9) return $urandom & 32'hFFFF_FFFC;
      return $urandom;
   endfunction

   initial begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      idle(1);
      // back-to-back fetches with the consumer always ready
      cyc(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h8000_0004, 1'b1, 1'b0, 1'b0);
      idle(3);
      // backpressure: third request must stall, then drain in order
      cyc(1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h8000_0104, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h8000_0108, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      idle(4);
`ifdef IFU_ITCM_RANGE_CHK_EN
      // out-of-window and misaligned fetches fault without an SRAM access
      cyc(1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h8000_0002, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h8001_0000, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h8000_FFFC, 1'b1, 1'b0, 1'b0);
      idle(3);
`endif
      // flush with two buffered responses
      cyc(1'b1, 32'h8000_0200, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h8000_0204, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      idle(3);
      // flush with a new request in the same cycle keeps only that request
      cyc(1'b1, 32'h8000_0300, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h8000_0304, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h8000_0040, 1'b1, 1'b1, 1'b0);
      idle(3);
      // reset with one buffered and one in-flight response
      cyc(1'b1, 32'h8000_0400, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h8000_0404, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 32'h8000_0408, 1'b1, 1'b0, 1'b0);
      idle(3);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 3) != 0), rand_pc(), ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0));
      end
      idle(6);
      chk("drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
